// File: rtl/plumbing_pkg.sv
// Shared constants and helpers for the plumbing dispatch blocks.
package plumbing_pkg;

    localparam int STALL_CNT_W     = 16;
    localparam int ADDRESS_W_DEF   = 2;
    localparam int DATA_W_DEF      = 8;
    localparam int ENTRY_W_DEF     = ADDRESS_W_DEF + DATA_W_DEF;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // One stored item is {address, data}; the address occupies the top bits.
    function automatic int entry_width(input int address_width, input int data_width);
        return address_width + data_width;
    endfunction

endpackage

// File: rtl/plumbing_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port, storage not reset.
module plumbing_fifo_mem
    import plumbing_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ENTRY_W_DEF,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/demux_dispatcher.sv
// Buffered in-order dispatch stage feeding the plumbing demultiplexor.
// Optional stall statistics are enabled by defining DEMUX_DISPATCHER_STALL_STATS_EN.
module demux_dispatcher
    import plumbing_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 2,
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [ADDRESS_WIDTH-1:0]      i_address,
    input  logic [DATA_WIDTH-1:0]         i_data,
    output logic                          o_x,
    output logic [ADDRESS_WIDTH-1:0]      o_address,
    output logic [DATA_WIDTH-1:0]         o_data,
    input  logic [(1<<ADDRESS_WIDTH)-1:0] i_ready,
    output logic [clog2(DEPTH):0]         o_count,
    output logic [STALL_CNT_W-1:0]        o_stall_cnt
);

    localparam int PW = clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = entry_width(ADDRESS_WIDTH, DATA_WIDTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ready_q, ready_d;

    logic                     head_valid;
    logic [EW-1:0]            head_entry;
    logic [ADDRESS_WIDTH-1:0] head_addr;
    logic                     push;
    logic                     pop;

    // Handshakes: upstream transfers on a rising edge with i_valid && o_ready;
    // downstream transfers on a rising edge with o_x && i_ready[o_address].
    // o_ready is registered from the next occupancy, so i_ready never reaches it combinationally.
    assign head_valid = (count_q != '0);
    assign head_addr  = head_entry[EW-1:DATA_WIDTH];
    assign push       = i_valid && ready_q;
    assign pop        = head_valid && i_ready[head_addr];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        ready_d = (count_d < CW'(DEPTH));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    plumbing_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW),
        .AW    (PW)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (push),
        .i_waddr (wr_ptr_q),
        .i_wdata ({i_address, i_data}),
        .i_raddr (rd_ptr_q),
        .o_rdata (head_entry)
    );

    // Storage is not reset, so the head is masked to zero while the FIFO is empty.
    assign o_x       = head_valid;
    assign o_address = head_valid ? head_addr : '0;
    assign o_data    = head_valid ? head_entry[DATA_WIDTH-1:0] : '0;
    assign o_ready   = ready_q;
    assign o_count   = count_q;

`ifdef DEMUX_DISPATCHER_STALL_STATS_EN
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (head_valid && !i_ready[head_addr] && (stall_q != '1)) begin
            stall_d = stall_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign o_stall_cnt = stall_q;
`else
    assign o_stall_cnt = '0;
`endif

endmodule
